soc_system_extruder_step_ctrl: RTL

//  Avalon-MM slave step/dir sequencer for the extruder stepper driver.
//  HPS writes a signed step count and step period, then starts a move. The block emits timed STEP/DIR/EN_N pulses.
//  The 1-bit extruder_type input (0=direct, 1=bowden) fixes DIR polarity. It is latched at each start.

---
 rtl/extruder_step_pkg.sv | 30 +++
 rtl/extruder_step_timer.sv | 33 +++
 rtl/soc_system_extruder_step_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/extruder_step_pkg.sv
// rtl/extruder_step_pkg.sv - register map, CTRL bit indices and FSM states for the extruder step sequencer
package extruder_step_pkg;

   localparam logic [1:0] ADDR_STEPS  = 2'd0;
   localparam logic [1:0] ADDR_PERIOD = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_REMAIN = 2'd3;

   // CTRL write bits
   localparam int CTRL_START    = 0;
   localparam int CTRL_ABORT    = 1;
   localparam int CTRL_CLEAR    = 2;
   localparam int CTRL_IRQ_MASK = 3;

   // CTRL read bits
   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int STAT_ABORTED   = 2;
   localparam int STAT_TYPE_LAT  = 3;
   localparam int STAT_TYPE_SYNC = 4;
   localparam int STAT_IRQ_MASK  = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_HIGH,
      ST_LOW
   } state_e;

endpackage

// File: rtl/extruder_step_timer.sv
// rtl/extruder_step_timer.sv - loadable down-counter with zero flag, shared by SETUP/HIGH/LOW phases
module extruder_step_timer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/soc_system_extruder_step_ctrl.sv
// rtl/soc_system_extruder_step_ctrl.sv - Avalon-MM step/dir sequencer top: CSRs, type synchroniser, FSM
// Optional irq output and CTRL irq_mask bit are built when EXTRUDER_STEP_IRQ_EN is defined.
module soc_system_extruder_step_ctrl
   import extruder_step_pkg::*;
#(
   parameter int PULSE_W   = 5,
   parameter int DIR_SETUP = 10,
   parameter int PERIOD_W  = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        extruder_type,
   output logic        step,
   output logic        dir,
   output logic        en_n
`ifdef EXTRUDER_STEP_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam logic [31:0] SETUP_LOAD = 32'(DIR_SETUP - 1);
   localparam logic [31:0] HIGH_LOAD  = 32'(PULSE_W - 1);
   localparam logic [31:0] MIN_PERIOD = 32'(2 * PULSE_W);

   state_e              state_q, state_d;
   logic [31:0]         steps_q, steps_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [31:0]         remain_q, remain_d;
   logic [31:0]         readdata_q, readdata_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;
   logic                dir_q, dir_d;
   logic                type_lat_q, type_lat_d;
   logic                abort_pend_q, abort_pend_d;
   logic                irq_mask_q, irq_mask_d;
   logic [1:0]          sync_q;

   logic        type_sync, busy, wr, wr_ctrl;
   logic        start, abort, clr;
   logic        tmr_load, tmr_zero;
   logic [31:0] tmr_val, period_ext, eff_period, low_load, abs_steps, ctrl_rd;

   assign type_sync = sync_q[1];
   assign busy      = (state_q != ST_IDLE);
   assign wr        = chipselect & ~write_n;
   assign wr_ctrl   = wr && (address == ADDR_CTRL);
   // Abort dominates: a combined start+abort write never launches a move.
   assign abort     = wr_ctrl & writedata[CTRL_ABORT];
   assign start     = wr_ctrl & writedata[CTRL_START] & ~writedata[CTRL_ABORT];
   assign clr       = wr_ctrl & writedata[CTRL_CLEAR];

   assign period_ext = 32'(period_q);
   assign eff_period = (period_ext < MIN_PERIOD) ? MIN_PERIOD : period_ext;
   assign low_load   = eff_period - 32'(PULSE_W) - 32'd1;
   assign abs_steps  = steps_q[31] ? (32'd0 - steps_q) : steps_q;

   always_comb begin
      ctrl_rd                 = '0;
      ctrl_rd[STAT_BUSY]      = busy;
      ctrl_rd[STAT_DONE]      = done_q;
      ctrl_rd[STAT_ABORTED]   = aborted_q;
      ctrl_rd[STAT_TYPE_LAT]  = type_lat_q;
      ctrl_rd[STAT_TYPE_SYNC] = type_sync;
      ctrl_rd[STAT_IRQ_MASK]  = irq_mask_q;
   end

   extruder_step_timer #(.W(32)) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d      = state_q;
      steps_d      = steps_q;
      period_d     = period_q;
      remain_d     = remain_q;
      done_d       = done_q;
      aborted_d    = aborted_q;
      dir_d        = dir_q;
      type_lat_d   = type_lat_q;
      abort_pend_d = abort_pend_q;
      irq_mask_d   = irq_mask_q;
      tmr_load     = 1'b0;
      tmr_val      = '0;
      readdata_d   = readdata_q;

      if (wr && address == ADDR_STEPS && !busy) steps_d = writedata;
      if (wr && address == ADDR_PERIOD) period_d = writedata[PERIOD_W-1:0];
`ifdef EXTRUDER_STEP_IRQ_EN
      if (wr_ctrl) irq_mask_d = writedata[CTRL_IRQ_MASK];
`endif
      if (clr) begin
         done_d    = 1'b0;
         aborted_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               type_lat_d = type_sync;
               done_d     = 1'b0;
               aborted_d  = 1'b0;
               if (steps_q != '0) begin
                  state_d  = ST_SETUP;
                  remain_d = abs_steps;
                  dir_d    = steps_q[31] ^ type_sync;
                  tmr_load = 1'b1;
                  tmr_val  = SETUP_LOAD;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_SETUP: begin
            if (abort) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
               done_d    = 1'b0;
            end else if (tmr_zero) begin
               state_d  = ST_HIGH;
               tmr_load = 1'b1;
               tmr_val  = HIGH_LOAD;
            end
         end
         ST_HIGH: begin
            if (abort) abort_pend_d = 1'b1;
            // An abort here waits for the pulse to finish so the driver never sees a runt.
            if (tmr_zero) begin
               remain_d     = remain_q - 32'd1;
               abort_pend_d = 1'b0;
               if (abort_pend_q || abort) begin
                  state_d   = ST_IDLE;
                  aborted_d = 1'b1;
                  done_d    = 1'b0;
               end else begin
                  state_d  = ST_LOW;
                  tmr_load = 1'b1;
                  tmr_val  = low_load;
               end
            end
         end
         ST_LOW: begin
            if (abort) begin
               state_d   = ST_IDLE;
               aborted_d = 1'b1;
               done_d    = 1'b0;
            end else if (tmr_zero) begin
               if (remain_q == '0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d  = ST_HIGH;
                  tmr_load = 1'b1;
                  tmr_val  = HIGH_LOAD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (chipselect) begin
         unique case (address)
            ADDR_STEPS:  readdata_d = steps_q;
            ADDR_PERIOD: readdata_d = period_ext;
            ADDR_CTRL:   readdata_d = ctrl_rd;
            default:     readdata_d = remain_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         steps_q      <= '0;
         period_q     <= '0;
         remain_q     <= '0;
         readdata_q   <= '0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         dir_q        <= 1'b0;
         type_lat_q   <= 1'b0;
         abort_pend_q <= 1'b0;
         irq_mask_q   <= 1'b0;
         sync_q       <= '0;
      end else begin
         state_q      <= state_d;
         steps_q      <= steps_d;
         period_q     <= period_d;
         remain_q     <= remain_d;
         readdata_q   <= readdata_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         dir_q        <= dir_d;
         type_lat_q   <= type_lat_d;
         abort_pend_q <= abort_pend_d;
         irq_mask_q   <= irq_mask_d;
         sync_q       <= {sync_q[0], extruder_type};
      end
   end

   assign readdata = readdata_q;
   assign step     = (state_q == ST_HIGH);
   assign dir      = dir_q;
   assign en_n     = ~busy;
`ifdef EXTRUDER_STEP_IRQ_EN
   assign irq      = (done_q | aborted_q) & irq_mask_q;
`endif

endmodule
